adc_sample_packer: RTL and testbench
====================================

Name: adc_sample_packer

Overview:
- Stage directly downstream of the PL ADC capture block, on the same ADC CMOS clock.
- Accepts the 14-bit sample stream for one acquisition frame and packs two samples per 32-bit word.
- Buffers the words in an internal FIFO and presents them on a ready/valid port to the SPI/PS readout logic.
- Reports frame completion, busy status and FIFO overflow.

Parameters:
FRAME_SAMPLES, 200000, samples accepted per frame (1..2^20-1)
FIFO_AW, 9, FIFO address width; depth = 2^FIFO_AW words

Ports:
i_CMOS_Clk  in  1  ADC CMOS clock; sole clock of the block
i_Rst  in  1  synchronous reset, active-high
i_Start  in  1  one-cycle pulse; starts a frame
i_Sample_Data  in  14  ADC sample
i_Sample_Valid  in  1  sample qualifier
o_Word_Data  out  32  packed word at FIFO head
o_Word_Valid  out  1  FIFO not empty
i_Word_Ready  in  1  consumer accepts the word
o_Fifo_Level  out  FIFO_AW+1  words currently stored
o_Busy  out  1  high in COLLECT and DRAIN
o_Frame_Done  out  1  one-cycle pulse at end of frame
o_Overflow  out  1  sticky; a word was dropped

Behaviour:
- Interface: one clock; reset is synchronous and active-high. Clock port i_CMOS_Clk, reset port i_Rst.
- Reset, on the clock edge with i_Rst=1, regardless of state:
  - state IDLE; FIFO pointers and level cleared (contents discarded).
  - o_Word_Valid=0, o_Fifo_Level=0, o_Busy=0, o_Frame_Done=0, o_Overflow=0, o_Word_Data=0.
  - Sample counter and half-word register cleared.
  - A reset mid-frame abandons the frame with no o_Frame_Done pulse.
- IDLE:
  - i_Sample_Valid ignored.
  - On i_Start=1: go to COLLECT, clear the sample counter, half-word register and o_Overflow.
  - FIFO contents are NOT flushed, so the previous frame's leftovers remain readable.
- COLLECT:
  - Each cycle with i_Sample_Valid=1 accepts one sample; the counter k is the number accepted before this one.
  - k even: store the sample in the half-word register.
  - k odd: push {2'b00, sample, 2'b00, half}.
  - If k+1 == FRAME_SAMPLES and k is even (FRAME_SAMPLES odd): push {18'b0, sample} instead of storing it.
  - After the FRAME_SAMPLES-th sample: go to DRAIN on the next edge.
  - Further valid samples are ignored; i_Start is ignored.
- DRAIN:
  - Samples and i_Start are ignored.
  - When the FIFO is empty, pulse o_Frame_Done for exactly 1 cycle and return to IDLE.
  - o_Busy falls in the same cycle as the o_Frame_Done pulse.
- FIFO:
  - Register-array FIFO, first-word-fall-through; o_Word_Data is the head word, o_Word_Valid = level != 0.
  - A pop occurs when o_Word_Valid && i_Word_Ready.
  - A push requested at edge N is visible at the FIFO head in cycle N+1 when the FIFO was empty. Latency from the odd sample to o_Word_Valid is 1 cycle.
  - Pointers wrap modulo 2^FIFO_AW.
  - o_Fifo_Level: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
- Full:
  - A push while level == 2^FIFO_AW with no pop in the same cycle is dropped and sets o_Overflow.
  - Push and pop in the same cycle while full both succeed.
  - o_Overflow stays set until i_Rst or the next accepted i_Start.
- Empty: i_Word_Ready with o_Word_Valid=0 has no effect; level never underflows.
- Word order equals sample order; sample 0 occupies the low half of word 0.

Test Plan:
- Reset, then i_Start with FRAME_SAMPLES=4 and samples 0x0001, 0x0002, 0x3FFF, 0x1234 on consecutive cycles, i_Word_Ready=1 -> words 0x00020001 then 0x12343FFF; o_Frame_Done pulses once after the FIFO empties; o_Busy=0 afterwards.
- FRAME_SAMPLES=3, samples 5, 6, 7 -> words 0x00060005 and 0x00000007; exactly 2 words popped.
- FIFO_AW=2, i_Word_Ready=0, 12 samples -> level saturates at 4 and o_Overflow=1. Then i_Word_Ready=1 -> the first 4 words come out unchanged and o_Frame_Done pulses. The next i_Start clears o_Overflow.
- Full FIFO with i_Word_Ready=1 while a push occurs -> level stays at 4, o_Overflow stays 0, no word is lost.
- i_Rst asserted mid-COLLECT after 2 of 4 samples -> next cycle level=0, o_Word_Valid=0, o_Busy=0, no o_Frame_Done; a new i_Start runs a clean 4-sample frame.
- Samples with i_Sample_Valid=1 in IDLE, and a second i_Start during COLLECT -> ignored; the word count and o_Frame_Done timing are unchanged.

Source files
------------

// File: rtl/adc_sample_packer.sv
// Packs pairs of 14-bit ADC samples into 32-bit words and buffers them in a
// first-word-fall-through FIFO read out over a ready/valid port.
module adc_sample_packer #(
   parameter int FRAME_SAMPLES = 200000,
   parameter int FIFO_AW       = 9
) (
   input  logic               i_CMOS_Clk,
   input  logic               i_Rst,
   input  logic               i_Start,
   input  logic [13:0]        i_Sample_Data,
   input  logic               i_Sample_Valid,
   output logic [31:0]        o_Word_Data,
   output logic               o_Word_Valid,
   input  logic               i_Word_Ready,
   output logic [FIFO_AW:0]   o_Fifo_Level,
   output logic               o_Busy,
   output logic               o_Frame_Done,
   output logic               o_Overflow
);

   localparam int DEPTH = 2 ** FIFO_AW;
   localparam logic [19:0] LAST_K = 20'(FRAME_SAMPLES - 1);
   localparam logic [FIFO_AW:0] FULL_LVL = {1'b1, {FIFO_AW{1'b0}}};

   typedef enum logic [1:0] {IDLE, COLLECT, DRAIN} state_t;

   state_t              state, state_nxt;
   logic                done_nxt;
   logic [19:0]         cnt;
   logic [13:0]         half;
   logic [31:0]         mem [DEPTH];
   logic [FIFO_AW-1:0]  wr_ptr, rd_ptr;
   logic [FIFO_AW:0]    level;
   logic                accept, last, push, pop, full, push_ok;
   logic [31:0]         push_word;

   assign accept    = (state == COLLECT) && i_Sample_Valid;
   assign last      = (cnt == LAST_K);
   // Odd samples complete a pair; an even final sample is flushed alone.
   assign push      = accept && (cnt[0] || last);
   assign push_word = cnt[0] ? {2'b00, i_Sample_Data, 2'b00, half}
                             : {18'b0, i_Sample_Data};
   assign full      = (level == FULL_LVL);
   assign pop       = o_Word_Valid && i_Word_Ready;
   assign push_ok   = push && (!full || pop);

   always_comb begin
      state_nxt = state;
      done_nxt  = 1'b0;
      case (state)
         IDLE:    if (i_Start) state_nxt = COLLECT;
         COLLECT: if (accept && last) state_nxt = DRAIN;
         DRAIN: begin
            if (level == '0) begin
               state_nxt = IDLE;
               done_nxt  = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge i_CMOS_Clk) begin
      if (i_Rst) begin
         state        <= IDLE;
         o_Frame_Done <= 1'b0;
         o_Overflow   <= 1'b0;
         cnt          <= '0;
         half         <= '0;
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         level        <= '0;
      end else begin
         state        <= state_nxt;
         o_Frame_Done <= done_nxt;
         if ((state == IDLE) && i_Start) begin
            cnt        <= '0;
            half       <= '0;
            o_Overflow <= 1'b0;
         end else if (accept) begin
            cnt <= cnt + 20'd1;
            if (!cnt[0]) half <= i_Sample_Data;
         end
         if (push && !push_ok) o_Overflow <= 1'b1;
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop)     rd_ptr <= rd_ptr + 1'b1;
         case ({push_ok, pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end

   // Storage carries no reset; only pointers and level define validity.
   always_ff @(posedge i_CMOS_Clk) begin
      if (push_ok) mem[wr_ptr] <= push_word;
   end

   assign o_Word_Valid = (level != '0);
   assign o_Word_Data  = o_Word_Valid ? mem[rd_ptr] : '0;
   assign o_Fifo_Level = level;
   assign o_Busy       = (state != IDLE);

endmodule

// File: tb/tb_adc_sample_packer.sv
// Bench for adc_sample_packer: directed and randomized frames compared each
// cycle against a queue-based reference model.
module tb_adc_sample_packer;

   localparam int FS    = 11;
   localparam int AW    = 2;
   localparam int DEPTH = 4;

   logic          clk = 1'b0;
   logic          rst, start, svld, ready;
   logic [13:0]   sdata;
   logic [31:0]   wdata;
   logic          wvalid, busy, fdone, ovf;
   logic [AW:0]   lvl;

   adc_sample_packer #(.FRAME_SAMPLES(FS), .FIFO_AW(AW)) dut (
      .i_CMOS_Clk    (clk),
      .i_Rst         (rst),
      .i_Start       (start),
      .i_Sample_Data (sdata),
      .i_Sample_Valid(svld),
      .o_Word_Data   (wdata),
      .o_Word_Valid  (wvalid),
      .i_Word_Ready  (ready),
      .o_Fifo_Level  (lvl),
      .o_Busy        (busy),
      .o_Frame_Done  (fdone),
      .o_Overflow    (ovf)
   );

   always #5 clk = ~clk;

   int npass = 0, nfail = 0, ntot = 0, ncyc = 0, ndone = 0;

   // Reference model: frame phase (0 idle, 1 collecting, 2 draining)
   int            phase = 0;
   int            nacc  = 0;
   logic [13:0]   mhalf = '0;
   logic [31:0]   q[$];
   bit            movf  = 1'b0;
   bit            mdone = 1'b0;
   logic [31:0]   popped[$];

   logic [13:0] dir [FS] = '{14'h0001, 14'h0002, 14'h3FFF, 14'h1234, 14'h0005,
                             14'h0006, 14'h0007, 14'h0008, 14'h0009, 14'h000A,
                             14'h000B};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ntot++;
      assert (obs === exp) npass++;
      else begin
         nfail++;
         $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, ncyc);
      end
   endtask

   task automatic model_step(input bit r, input bit st, input bit sv,
                             input logic [13:0] sd, input bit rdy);
      bit          pop, havepush;
      logic [31:0] w;
      if (r) begin
         phase = 0; nacc = 0; mhalf = '0; q.delete(); movf = 0; mdone = 0;
         return;
      end
      pop      = (q.size() != 0) && rdy;
      havepush = 0;
      w        = '0;
      mdone    = 0;
      case (phase)
         0: if (st) begin phase = 1; nacc = 0; movf = 0; end
         1: if (sv) begin
               if (nacc % 2 == 1) begin
                  w = {2'b00, sd, 2'b00, mhalf}; havepush = 1;
               end else if (nacc == FS - 1) begin
                  w = {18'b0, sd}; havepush = 1;
               end else mhalf = sd;
               nacc++;
               if (nacc == FS) phase = 2;
            end
         default: if (q.size() == 0) begin phase = 0; mdone = 1; end
      endcase
      if (pop) void'(q.pop_front());
      if (havepush) begin
         if (q.size() < DEPTH) q.push_back(w);
         else movf = 1;
      end
   endtask

   task automatic check_all();
      chk("valid", {31'b0, wvalid}, {31'b0, q.size() != 0});
      chk("level", 32'(lvl), 32'(q.size()));
      if (q.size() != 0) chk("data", wdata, q[0]);
      chk("busy", {31'b0, busy}, {31'b0, phase != 0});
      chk("frame_done", {31'b0, fdone}, {31'b0, mdone});
      chk("overflow", {31'b0, ovf}, {31'b0, movf});
      if (fdone) ndone++;
   endtask

   task automatic cyc(input bit r, input bit st, input bit sv,
                      input logic [13:0] sd, input bit rdy);
      rst = r; start = st; svld = sv; sdata = sd; ready = rdy;
      if (wvalid && rdy && !r) popped.push_back(wdata);
      @(posedge clk);
      ncyc++;
      model_step(r, st, sv, sd, rdy);
      #1;
      check_all();
   endtask

   task automatic drain(input int maxc);
      for (int i = 0; i < maxc && phase != 0; i++) cyc(0, 0, 0, 14'h0, 1);
      cyc(0, 0, 0, 14'h0, 1);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; svld = 1'b0; sdata = '0; ready = 1'b0;
      cyc(1, 0, 0, 14'h0, 0);
      cyc(1, 0, 0, 14'h0, 1);
      chk("rst_data", wdata, 32'h0);

      // Directed frame, consumer always ready
      popped.delete(); ndone = 0;
      cyc(0, 1, 0, 14'h0, 1);
      for (int i = 0; i < FS; i++) cyc(0, 0, 1, dir[i], 1);
      drain(40);
      chk("w0", popped[0], 32'h00020001);
      chk("w1", popped[1], 32'h12343FFF);
      chk("w2", popped[2], 32'h00060005);
      chk("w5_tail", popped[5], 32'h0000000B);
      chk("nwords", 32'(popped.size()), 32'd6);
      chk("done_count", 32'(ndone), 32'd1);
      chk("idle_busy", {31'b0, busy}, 32'd0);

      // Samples in IDLE ignored; second start during collection ignored
      for (int i = 0; i < 4; i++) cyc(0, 0, 1, 14'($urandom), 1);
      popped.delete(); ndone = 0;
      cyc(0, 1, 0, 14'h0, 1);
      for (int i = 0; i < FS; i++) cyc(0, (i == 3), 1, dir[i], 1);
      drain(40);
      chk("restart_nwords", 32'(popped.size()), 32'd6);
      chk("restart_done", 32'(ndone), 32'd1);

      // Reset mid-collection, then a clean frame
      ndone = 0;
      cyc(0, 1, 0, 14'h0, 0);
      cyc(0, 0, 1, 14'h0111, 0);
      cyc(0, 0, 1, 14'h0222, 0);
      cyc(1, 0, 0, 14'h0, 0);
      chk("midrst_level", 32'(lvl), 32'd0);
      chk("midrst_busy", {31'b0, busy}, 32'd0);
      popped.delete();
      cyc(0, 1, 0, 14'h0, 1);
      for (int i = 0; i < FS; i++) cyc(0, 0, 1, dir[i], 1);
      drain(40);
      chk("midrst_done", 32'(ndone), 32'd1);
      chk("midrst_w0", popped[0], 32'h00020001);

      // Full FIFO with a simultaneous push and pop
      cyc(0, 1, 0, 14'h0, 0);
      for (int i = 0; i < 9; i++) cyc(0, 0, 1, dir[i], 0);
      chk("full_level", 32'(lvl), 32'd4);
      cyc(0, 0, 1, dir[9], 1);
      chk("full_pushpop_level", 32'(lvl), 32'd4);
      chk("full_pushpop_ovf", {31'b0, ovf}, 32'd0);
      cyc(0, 0, 1, dir[10], 1);
      drain(40);

      // Overflow: consumer stalled through the whole frame
      popped.delete();
      cyc(0, 1, 0, 14'h0, 0);
      for (int i = 0; i < FS; i++) cyc(0, 0, 1, dir[i], 0);
      for (int i = 0; i < 3; i++) cyc(0, 0, 0, 14'h0, 0);
      chk("ovf_set", {31'b0, ovf}, 32'd1);
      chk("ovf_level", 32'(lvl), 32'd4);
      drain(40);
      chk("ovf_w3", popped[3], 32'h00080007);
      chk("ovf_nwords", 32'(popped.size()), 32'd4);
      chk("ovf_sticky", {31'b0, ovf}, 32'd1);
      cyc(0, 1, 0, 14'h0, 1);
      chk("ovf_cleared", {31'b0, ovf}, 32'd0);
      drain(400);

      // Randomized frames with sample gaps and consumer back-pressure
      for (int f = 0; f < 6; f++) begin
         cyc(0, 1, 0, 14'h0, $urandom_range(0, 1) == 1);
         for (int i = 0; i < 400 && phase != 0; i++)
            cyc(0, $urandom_range(0, 9) == 0, $urandom_range(0, 99) < 70,
                14'($urandom), $urandom_range(0, 99) < (f < 3 ? 50 : 20));
         for (int i = 0; i < 3; i++)
            cyc(0, 0, $urandom_range(0, 1) == 1, 14'($urandom), 1);
      end

      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end

endmodule
